// File: rtl/fb_pkg.sv
// Shared types and geometry for the 160x120 frame-buffer arbiter.
package fb_pkg;
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;

  typedef logic [14:0] addr_t;
  typedef logic [11:0] colour_t;

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_CLEAR,
    CLR_DONE
  } clr_state_e;

  typedef struct packed {
    addr_t   addr;
    colour_t colour;
  } wr_entry_t;
endpackage

// File: rtl/fb_wr_fifo.sv
// Small paint-write FIFO; the head entry is visible combinationally on dout.
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  // Full blocks a push even when a pop happens in the same cycle, and an
  // empty FIFO cannot pop the word being pushed in that same cycle.
  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/framebuffer_arbiter.sv
// Single-port frame-buffer arbiter: display reads > screen clear > queued paint writes.
// Define FB_CLEAR_EN to build the full-screen clear engine.
module framebuffer_arbiter #(
  parameter int FB_DEPTH    = fb_pkg::FB_DEPTH,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        disp_req,
  input  logic [14:0] disp_addr,
  output logic [11:0] disp_data,
  output logic        disp_valid,
  input  logic        wr_valid,
  input  logic [14:0] wr_addr,
  input  logic [11:0] wr_colour,
  output logic        wr_ready,
  input  logic        clr_start,
  input  logic [11:0] clr_colour,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        oob_err,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [11:0] ram_wdata,
  input  logic [11:0] ram_rdata
);
  import fb_pkg::*;

  localparam addr_t LAST_ADDR = addr_t'(FB_DEPTH - 1);

  wr_entry_t fifo_din;
  wr_entry_t fifo_dout;
  logic      fifo_pop;
  logic      fifo_full;
  logic      fifo_empty;
  logic      disp_grant;
  logic      clr_active;
  addr_t     clr_addr;
  colour_t   clr_fill;
  logic      clr_write;
  logic      oob_hit;
  logic      disp_valid_reg;
  logic      oob_err_reg;

  assign fifo_din = {wr_addr, wr_colour};
  assign wr_ready = !fifo_full;

  fb_wr_fifo #(
    .DEPTH (WFIFO_DEPTH),
    .WIDTH ($bits(wr_entry_t))
  ) u_wr_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_valid),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Gated so the RAM address bus sits at zero while reset is held.
  assign disp_grant = disp_req && reset_n;

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    fifo_pop  = 1'b0;
    clr_write = 1'b0;
    oob_hit   = 1'b0;
    if (disp_grant) begin
      ram_addr = disp_addr;
    end else if (clr_active) begin
      ram_addr  = clr_addr;
      ram_we    = 1'b1;
      ram_wdata = clr_fill;
      clr_write = 1'b1;
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      if (fifo_dout.addr > LAST_ADDR) begin
        oob_hit = 1'b1;
      end else begin
        ram_addr  = fifo_dout.addr;
        ram_we    = 1'b1;
        ram_wdata = fifo_dout.colour;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_valid_reg <= 1'b0;
      oob_err_reg    <= 1'b0;
    end else begin
      disp_valid_reg <= disp_grant;
      oob_err_reg    <= oob_err_reg | oob_hit;
    end
  end

  assign disp_valid = disp_valid_reg;
  assign disp_data  = disp_valid_reg ? ram_rdata : '0;
  assign oob_err    = oob_err_reg;

`ifdef FB_CLEAR_EN
  clr_state_e clr_state_reg, clr_state_next;
  addr_t      clr_cnt_reg, clr_cnt_next;
  colour_t    clr_fill_reg, clr_fill_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_state_reg <= CLR_IDLE;
      clr_cnt_reg   <= '0;
      clr_fill_reg  <= '0;
    end else begin
      clr_state_reg <= clr_state_next;
      clr_cnt_reg   <= clr_cnt_next;
      clr_fill_reg  <= clr_fill_next;
    end
  end

  // The counter only advances on cycles the display leaves the RAM free.
  always_comb begin
    clr_state_next = clr_state_reg;
    clr_cnt_next   = clr_cnt_reg;
    clr_fill_next  = clr_fill_reg;
    case (clr_state_reg)
      CLR_IDLE: begin
        if (clr_start) begin
          clr_state_next = CLR_CLEAR;
          clr_cnt_next   = '0;
          clr_fill_next  = clr_colour;
        end
      end
      CLR_CLEAR: begin
        if (clr_write) begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == LAST_ADDR) clr_state_next = CLR_DONE;
        end
      end
      CLR_DONE: clr_state_next = CLR_IDLE;
      default:  clr_state_next = CLR_IDLE;
    endcase
  end

  assign clr_active = (clr_state_reg == CLR_CLEAR);
  assign clr_addr   = clr_cnt_reg;
  assign clr_fill   = clr_fill_reg;
  assign clr_busy   = (clr_state_reg != CLR_IDLE);
  assign clr_done   = (clr_state_reg == CLR_DONE);
`else
  logic unused_clr;

  assign clr_active = 1'b0;
  assign clr_addr   = '0;
  assign clr_fill   = '0;
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
  assign unused_clr = ^{clr_start, clr_colour, clr_write};
`endif
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed scoreboard bench for framebuffer_arbiter with a behavioural 1-cycle RAM.
module tb_framebuffer_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        disp_req;
  logic [14:0] disp_addr;
  logic [11:0] disp_data;
  logic        disp_valid;
  logic        wr_valid;
  logic [14:0] wr_addr;
  logic [11:0] wr_colour;
  logic        wr_ready;
  logic        clr_start;
  logic [11:0] clr_colour;
  logic        clr_busy;
  logic        clr_done;
  logic        oob_err;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  int checks = 0;
  int errors = 0;
  bit done_seen;
  logic prev_req;

  logic [26:0] exp_wr[$];
  logic [11:0] exp_disp[$];
  logic [11:0] pre [3] = '{12'hA00, 12'h0B0, 12'h00C};
  logic [11:0] mem [0:32767];

  framebuffer_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_colour  (wr_colour),
    .wr_ready   (wr_ready),
    .clr_start  (clr_start),
    .clr_colour (clr_colour),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .oob_err    (oob_err),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: preload on reset, registered read.
  always @(posedge clk) begin
    if (!reset_n) begin
      mem[0] <= pre[0];
      mem[1] <= pre[1];
      mem[2] <= pre[2];
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pop_wr();
    if (exp_wr.size() == 0) return 32'hDEAD_BEEF;
    return {5'b0, exp_wr.pop_front()};
  endfunction

  function automatic logic [31:0] pop_disp();
    if (exp_disp.size() == 0) return 32'hDEAD_BEEF;
    return {20'b0, exp_disp.pop_front()};
  endfunction

  // Output monitor: every RAM write and display return is scored against the queues.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_req <= 1'b0;
    end else begin
      check("disp_valid_timing", 32'(disp_valid), 32'(prev_req));
      if (disp_req) check("disp_no_we", 32'(ram_we), 32'd0);
      if (disp_valid) check("disp_data", 32'(disp_data), pop_disp());
      if (ram_we) check("ram_write", 32'({ram_addr, ram_wdata}), pop_wr());
      prev_req <= disp_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [14:0] a, input logic [11:0] c, input bit expect_write);
    bit ok;
    ok = 1'b0;
    wr_valid  = 1'b1;
    wr_addr   = a;
    wr_colour = c;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (wr_ready) begin
        ok = 1'b1;
        if (expect_write) exp_wr.push_back({a, c});
      end
      tick();
    end
    wr_valid = 1'b0;
    check("wr_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input string tag, input int bound);
    for (int n = 0; n < bound && exp_wr.size() != 0; n++) tick();
    check(tag, exp_wr.size(), 32'd0);
  endtask

  task automatic disp_read(input logic [14:0] a, input logic [11:0] expv);
    disp_req  = 1'b1;
    disp_addr = a;
    exp_disp.push_back(expv);
    tick();
    disp_req = 1'b0;
    tick();
    check("disp_read_done", exp_disp.size(), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; disp_req = 1'b0; disp_addr = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_colour = '0; clr_start = 1'b0; clr_colour = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_disp_data", 32'(disp_data), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_clr_done", 32'(clr_done), 32'd0);
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    check("rst_oob_err", 32'(oob_err), 32'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    tick();

    // Streamed display reads of preloaded words
    for (int i = 0; i < 3; i++) begin
      disp_req  = 1'b1;
      disp_addr = 15'(i);
      exp_disp.push_back(pre[i]);
      tick();
    end
    disp_req = 1'b0;
    tick();
    tick();
    check("disp_stream_done", exp_disp.size(), 32'd0);

    // FIFO fills behind display traffic, then drains in order
    disp_req  = 1'b1;
    disp_addr = '0;
    for (int i = 0; i < 5; i++) begin
      wr_valid  = 1'b1;
      wr_addr   = 15'(10 + i);
      wr_colour = 12'h100 + 12'(i);
      exp_disp.push_back(12'hA00);
      @(negedge clk);
      check("wr_ready_fill", 32'(wr_ready), 32'(i < 4));
      if (wr_ready) exp_wr.push_back({wr_addr, wr_colour});
      tick();
    end
    disp_req = 1'b0;
    offer(15'd14, 12'h104, 1'b1);
    wait_drain("drain_fifo", 20);

    // Last valid address, then out-of-range, then sticky flag
    offer(15'd19199, 12'h5A5, 1'b1);
    @(negedge clk);
    check("min_latency_we", 32'(ram_we), 32'd1);
    wait_drain("drain_last", 10);
    check("oob_clear_at_last", 32'(oob_err), 32'd0);
    offer(15'd19200, 12'h123, 1'b0);
    repeat (3) tick();
    check("oob_set", 32'(oob_err), 32'd1);
    offer(15'd7, 12'h777, 1'b1);
    wait_drain("drain_after_oob", 10);
    check("oob_sticky", 32'(oob_err), 32'd1);
    disp_read(15'd7, 12'h777);
    disp_read(15'd12, 12'h102);
    disp_read(15'd19199, 12'h5A5);

`ifdef FB_CLEAR_EN
    // Full-screen clear, with a second start ignored mid-clear
    clr_colour = 12'hFFF;
    clr_start  = 1'b1;
    for (int a = 0; a < 19200; a++) exp_wr.push_back({15'(a), 12'hFFF});
    tick();
    clr_start  = 1'b0;
    clr_colour = '0;
    @(negedge clk);
    check("clr_busy_set", 32'(clr_busy), 32'd1);
    repeat (50) tick();
    clr_colour = 12'h111;
    clr_start  = 1'b1;
    tick();
    clr_start  = 1'b0;
    done_seen  = 1'b0;
    for (int n = 0; n < 20000 && !done_seen; n++) begin
      @(negedge clk);
      if (clr_done) begin
        done_seen = 1'b1;
        check("clr_done_after_last", exp_wr.size(), 32'd0);
        check("clr_busy_in_done", 32'(clr_busy), 32'd1);
      end
    end
    check("clr_done_seen", 32'(done_seen), 32'd1);
    @(negedge clk);
    check("clr_busy_fall", 32'(clr_busy), 32'd0);
    check("clr_done_single", 32'(clr_done), 32'd0);
    tick();

    // Clear abandoned by reset with a paint write still queued
    clr_colour = 12'h333;
    clr_start  = 1'b1;
    for (int a = 0; a < 100; a++) exp_wr.push_back({15'(a), 12'h333});
    tick();
    clr_start = 1'b0;
    repeat (5) tick();
    wr_valid  = 1'b1;
    wr_addr   = 15'd5;
    wr_colour = 12'h0F0;
    @(negedge clk);
    check("wr_ready_in_clear", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    wait_drain("clr_reach_100", 200);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_clr_busy", 32'(clr_busy), 32'd0);
    check("abort_ram_we", 32'(ram_we), 32'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_abort_busy", 32'(clr_busy), 32'd0);
    check("post_abort_wr_ready", 32'(wr_ready), 32'd1);
    check("post_abort_oob", 32'(oob_err), 32'd0);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(clr_done), 32'd0);
    end
    tick();
    disp_read(15'd5, 12'h333);
    disp_read(15'd100, 12'hFFF);
`else
    // Clear disabled: start pulse must do nothing
    clr_colour = 12'hABC;
    clr_start  = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("noclr_ram_we", 32'(ram_we), 32'd0);
      check("noclr_busy", 32'(clr_busy), 32'd0);
      check("noclr_done", 32'(clr_done), 32'd0);
    end
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("oob_cleared_by_reset", 32'(oob_err), 32'd0);
    tick();
`endif

    check("final_wr_queue", exp_wr.size(), 32'd0);
    check("final_disp_queue", exp_disp.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
